// File: rtl/enc4to2_seq.sv
// rtl/enc4to2_seq.sv - registered 4-to-2 encoder with valid/ready handshake and error counter
// Optional ROUND_ROBIN_EN: multi-hot inputs grant round-robin from rr_ptr instead of highest bit.
module enc4to2_seq #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           Z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           I,
  output logic                 enable,
  output logic                 multi,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                 out_valid_q, out_valid_d;
  logic [1:0]           i_q, i_d;
  logic                 enable_q, enable_d;
  logic                 multi_q, multi_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       accept;
  logic       z_any;
  logic       z_multi;
  logic [1:0] grant;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign z_any    = |Z;
  // clearing the lowest set bit leaves something only if two or more bits were set
  assign z_multi  = (Z & (Z - 4'd1)) != 4'd0;

`ifdef ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  // scan offsets downward so the nearest set bit at or above rr_ptr wins
  always_comb begin
    grant = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (Z[rr_ptr_q + 2'(k)]) grant = rr_ptr_q + 2'(k);
    end
    rr_ptr_d = rr_ptr_q;
    if (accept && z_any) rr_ptr_d = grant + 2'd1;
  end
`else
  always_comb begin
    if (Z[3])      grant = 2'd3;
    else if (Z[2]) grant = 2'd2;
    else if (Z[1]) grant = 2'd1;
    else           grant = 2'd0;
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    i_d         = i_q;
    enable_d    = enable_q;
    multi_d     = multi_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      i_d         = grant;
      enable_d    = z_any;
      multi_d     = z_multi;
      if ((!z_any || z_multi) && (err_cnt_q != {ERR_CNT_W{1'b1}}))
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      i_q         <= 2'd0;
      enable_q    <= 1'b0;
      multi_q     <= 1'b0;
      err_cnt_q   <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q    <= 2'd0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      i_q         <= i_d;
      enable_q    <= enable_d;
      multi_q     <= multi_d;
      err_cnt_q   <= err_cnt_d;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign I         = i_q;
  assign enable    = enable_q;
  assign multi     = multi_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_enc4to2_seq.sv
// tb/tb_enc4to2_seq.sv - self-checking bench for enc4to2_seq, default and ROUND_ROBIN_EN builds
module tb_enc4to2_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] Z = 4'd0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, enable, multi;
  logic [1:0] I;
  logic [7:0] err_cnt;

  logic       sat_in_ready, sat_out_valid, sat_enable, sat_multi;
  logic [1:0] sat_i;
  logic [1:0] sat_err_cnt;

  always #5 clk = ~clk;

  enc4to2_seq #(.ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .Z(Z),
    .out_valid(out_valid), .out_ready(out_ready), .I(I), .enable(enable),
    .multi(multi), .err_cnt(err_cnt)
  );

  enc4to2_seq #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready), .Z(Z),
    .out_valid(sat_out_valid), .out_ready(out_ready), .I(sat_i), .enable(sat_enable),
    .multi(sat_multi), .err_cnt(sat_err_cnt)
  );

  typedef struct {
    logic [1:0] i;
    logic       en;
    logic       m;
  } res_t;

  typedef struct {
    logic       v;
    logic [3:0] z;
    logic       ordy;
    logic [1:0] i;
    logic       en;
    logic       m;
  } vec_t;

  res_t exp_q[$];
  res_t m_last;
  logic m_full;
  int   m_err;
  int   m_err2;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_full = 1'b0;
    m_last = '{2'd0, 1'b0, 1'b0};
    m_err  = 0;
    m_err2 = 0;
  endtask

  task automatic do_reset(input logic [3:0] z, input logic ordy);
    in_valid  = 1'b1;
    Z         = z;
    out_ready = ordy;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // called at posedge+1: drive, check outputs of the previous edge, advance model, clock
  task automatic cycle(input logic v, input logic [3:0] z, input logic ordy,
                       input logic [1:0] ei, input logic een, input logic em);
    res_t h;
    logic acc;
    in_valid  = v;
    Z         = z;
    out_ready = ordy;
    #1;
    check("out_valid", out_valid, m_full);
    check("in_ready", in_ready, !m_full || ordy);
    check("sat_out_valid", sat_out_valid, m_full);
    h = m_full ? exp_q[0] : m_last;
    check("I", I, h.i);
    check("enable", enable, h.en);
    check("multi", multi, h.m);
    check("err_cnt", err_cnt, m_err);
    check("sat_err_cnt", sat_err_cnt, m_err2);
    acc = v && (!m_full || ordy);
    if (m_full && ordy) begin
      m_last = exp_q.pop_front();
      m_full = 1'b0;
    end
    if (acc) begin
      exp_q.push_back('{ei, een, em});
      m_full = 1'b1;
      if (!een || em) begin
        if (m_err < 255) m_err++;
        if (m_err2 < 3) m_err2++;
      end
    end
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];

  initial begin
    // T1 round-trip table: dec2to4 outputs for I=0..3, decoder disabled, idle gap, stall
    tbl.push_back('{1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b1000, 1'b0, 2'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0});
`ifndef ROUND_ROBIN_EN
    tbl.push_back('{1'b1, 4'b0110, 1'b1, 2'd2, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 2'd3, 1'b1, 1'b1});
`endif
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0});

    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_I", I, 2'd0);
    check("rst_err_cnt", err_cnt, 8'd0);

    foreach (tbl[k])
      cycle(tbl[k].v, tbl[k].z, tbl[k].ordy, tbl[k].i, tbl[k].en, tbl[k].m);

    // T2 backpressure
    cycle(1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);

`ifndef ROUND_ROBIN_EN
    // T3 multi-hot fixed priority
    do_reset(4'b0000, 1'b1);
    cycle(1'b1, 4'b1010, 1'b1, 2'd3, 1'b1, 1'b1);
    cycle(1'b1, 4'b0011, 1'b1, 2'd1, 1'b1, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    check("t3_err_cnt", err_cnt, 8'd2);
`endif

    // T6 reset with a held result and a simultaneous offered input
    cycle(1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    do_reset(4'b1000, 1'b1);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_I", I, 2'd0);
    check("t6_err_cnt", err_cnt, 8'd0);
    cycle(1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);

`ifdef ROUND_ROBIN_EN
    // T4 round-robin grants
    do_reset(4'b0000, 1'b0);
    cycle(1'b1, 4'b1111, 1'b1, 2'd0, 1'b1, 1'b1);
    cycle(1'b1, 4'b1111, 1'b1, 2'd1, 1'b1, 1'b1);
    cycle(1'b1, 4'b1111, 1'b1, 2'd2, 1'b1, 1'b1);
    cycle(1'b1, 4'b1111, 1'b1, 2'd3, 1'b1, 1'b1);
    cycle(1'b1, 4'b1111, 1'b1, 2'd0, 1'b1, 1'b1);
    cycle(1'b1, 4'b1001, 1'b1, 2'd3, 1'b1, 1'b1);
    cycle(1'b1, 4'b1001, 1'b1, 2'd0, 1'b1, 1'b1);
    cycle(1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 4'b0110, 1'b1, 2'd1, 1'b1, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
`endif

    // T5 saturation of the 2-bit counter
    do_reset(4'b0000, 1'b0);
    repeat (5) cycle(1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    check("t5_sat_err_cnt", sat_err_cnt, 2'd3);
    check("t5_err_cnt", err_cnt, 8'd5);
    cycle(1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    check("t5_sat_hold", sat_err_cnt, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
